sarray_os: RTL

Parametrised output-stationary systolic matrix-multiply array; successor to the fixed 64x64 array. It accepts a command (K depth, accumulate flag, signedness), then streams K beats of left (A column) and top (B row) vectors through internal skew registers into a ROWS x COLS grid of MAC PEs. Once the flush window closes, it drains the accumulated C tile one row per beat over a valid/ready port. It sits between the tile loader and the post-store (storec) path.

---
 rtl/sarray_os_pkg.sv | 17 +
 rtl/sarray_os_pe.sv | 67 ++++++
 rtl/sarray_os.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sarray_os_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
package sarray_os_pkg;

    localparam int K_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } state_e;

    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/sarray_os_pe.sv
// One MAC cell: forwards A rightward and B downward, accumulates a*b when both operands are valid.
module sarray_os_pe
    import sarray_os_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_i,
    input  logic              a_vld_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              b_vld_i,
    input  logic              signed_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] a_o,
    output logic              a_vld_o,
    output logic [DATA_W-1:0] b_o,
    output logic              b_vld_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W-1:0] a_q, b_q;
    logic              a_vld_q, b_vld_q;
    logic [ACC_W-1:0]  acc_q;

    // Full-width product, then sign- or zero-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] ext_prod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic              sgn);
        logic signed [2*DATA_W-1:0] as, bs, ps;
        logic        [2*DATA_W-1:0] au, bu, pu;
        as = (2*DATA_W)'($signed(a));
        bs = (2*DATA_W)'($signed(b));
        au = (2*DATA_W)'(a);
        bu = (2*DATA_W)'(b);
        ps = as * bs;
        pu = au * bu;
        return sgn ? ACC_W'(ps) : ACC_W'(pu);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            a_q     <= a_i;
            b_q     <= b_i;
            a_vld_q <= a_vld_i;
            b_vld_q <= b_vld_i;
            if (clr_i)
                acc_q <= '0;
            else if (a_vld_i && b_vld_i)
                acc_q <= acc_q + ext_prod(a_i, b_i, signed_i);
        end
    end

    assign a_o     = a_q;
    assign a_vld_o = a_vld_q;
    assign b_o     = b_q;
    assign b_vld_o = b_vld_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/sarray_os.sv
// ROWS x COLS output-stationary systolic matmul: skewed operand feed, PE grid, job FSM and row drain.
module sarray_os
    import sarray_os_pkg::*;
#(
    parameter  int ROWS   = 8,
    parameter  int COLS   = 8,
    parameter  int DATA_W = 8,
    parameter  int ACC_W  = 32,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [K_W-1:0]         cmd_k_i,
    input  logic                   cmd_acc_i,
    input  logic                   cmd_signed_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [ROWS*DATA_W-1:0] in_left_data_i,
    input  logic [COLS*DATA_W-1:0] in_top_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [RW-1:0]          out_row_o,
    output logic [COLS*ACC_W-1:0]  out_data_o,
    output logic                   out_last_o,
    output logic                   busy_o
);

    localparam int FL = flush_len(ROWS, COLS);
    localparam int FW = $clog2(FL + 1);

    state_e         state_q;
    logic [K_W-1:0] beats_q;
    logic [FW-1:0]  flush_q;
    logic [RW-1:0]  row_q;
    logic           signed_q, cmd_rdy_q, in_rdy_q, out_vld_q, busy_q;

    logic cmd_fire, beat, clr;
    assign cmd_fire = cmd_valid_i && cmd_rdy_q;
    assign beat     = in_valid_i && in_rdy_q;
    assign clr      = cmd_fire && !cmd_acc_i;

    logic [DATA_W-1:0] ah  [ROWS][COLS+1];
    logic              avh [ROWS][COLS+1];
    logic [DATA_W-1:0] bv  [ROWS+1][COLS];
    logic              bvv [ROWS+1][COLS];
    logic [ACC_W-1:0]  acc_w [ROWS][COLS];

    // Skew: each row/column has one capture register plus r (or c) delay registers.
    for (genvar r = 0; r < ROWS; r++) begin : g_lskew
        logic [DATA_W-1:0] d_q [0:r];
        logic              v_q [0:r];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= r; j++) begin
                    d_q[j] <= '0;
                    v_q[j] <= 1'b0;
                end
            end else begin
                d_q[0] <= in_left_data_i[r*DATA_W +: DATA_W];
                v_q[0] <= beat;
                for (int j = 1; j <= r; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end
        assign ah[r][0]  = d_q[r];
        assign avh[r][0] = v_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_tskew
        logic [DATA_W-1:0] d_q [0:c];
        logic              v_q [0:c];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= c; j++) begin
                    d_q[j] <= '0;
                    v_q[j] <= 1'b0;
                end
            end else begin
                d_q[0] <= in_top_data_i[c*DATA_W +: DATA_W];
                v_q[0] <= beat;
                for (int j = 1; j <= c; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end
        assign bv[0][c]  = d_q[c];
        assign bvv[0][c] = v_q[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sarray_os_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .a_i      (ah[r][c]),
                .a_vld_i  (avh[r][c]),
                .b_i      (bv[r][c]),
                .b_vld_i  (bvv[r][c]),
                .signed_i (signed_q),
                .clr_i    (clr),
                .a_o      (ah[r][c+1]),
                .a_vld_o  (avh[r][c+1]),
                .b_o      (bv[r+1][c]),
                .b_vld_o  (bvv[r+1][c]),
                .acc_o    (acc_w[r][c])
            );
        end
    end

    // Handshake flags are registered from the next state, so they change only on edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beats_q   <= '0;
            flush_q   <= '0;
            row_q     <= '0;
            signed_q  <= 1'b0;
            cmd_rdy_q <= 1'b1;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (cmd_fire) begin
                    signed_q  <= cmd_signed_i;
                    beats_q   <= cmd_k_i;
                    busy_q    <= 1'b1;
                    cmd_rdy_q <= 1'b0;
                    if (cmd_k_i != '0) begin
                        state_q  <= ST_FEED;
                        in_rdy_q <= 1'b1;
                    end else begin
                        state_q   <= ST_DRAIN;
                        out_vld_q <= 1'b1;
                    end
                end
                ST_FEED: if (beat) begin
                    beats_q <= beats_q - K_W'(1);
                    if (beats_q == K_W'(1)) begin
                        state_q  <= ST_FLUSH;
                        in_rdy_q <= 1'b0;
                        flush_q  <= FW'(FL - 1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == '0) begin
                        state_q   <= ST_DRAIN;
                        out_vld_q <= 1'b1;
                    end else begin
                        flush_q <= flush_q - FW'(1);
                    end
                end
                ST_DRAIN: if (out_ready_i) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_q   <= ST_IDLE;
                        row_q     <= '0;
                        out_vld_q <= 1'b0;
                        busy_q    <= 1'b0;
                        cmd_rdy_q <= 1'b1;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_data_o = '0;
        for (int c = 0; c < COLS; c++)
            out_data_o[c*ACC_W +: ACC_W] = acc_w[row_q][c];
    end

    assign cmd_ready_o = cmd_rdy_q;
    assign in_ready_o  = in_rdy_q;
    assign out_valid_o = out_vld_q;
    assign out_row_o   = row_q;
    assign out_last_o  = out_vld_q && (row_q == RW'(ROWS - 1));
    assign busy_o      = busy_q;

endmodule
